// File: rtl/bitcoin_pkg.sv
// Shared types and constants for the nonce post-processing blocks.
// State encoding, result record offsets and running-minimum seed.
package bitcoin_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR_HASH,
    S_WR_NONCE,
    S_WR_FOUND,
    S_FIN
  } state_e;

  localparam logic [15:0] RES_HASH_OFS  = 16'd0;
  localparam logic [15:0] RES_NONCE_OFS = 16'd1;
  localparam logic [15:0] RES_FOUND_OFS = 16'd2;

  localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/min_tracker.sv
// Running minimum of a stream of H0 words with the index of its
// first occurrence; min_nxt_o exposes the value after this beat.
module min_tracker
  import bitcoin_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  idx_i,
  output logic [31:0] min_o,
  output logic [7:0]  idx_o,
  output logic [31:0] min_nxt_o
);

  logic [31:0] min_q, min_d;
  logic [7:0]  idx_q, idx_d;

  // Strict compare keeps the earlier index on ties.
  always_comb begin
    min_d = min_q;
    idx_d = idx_q;
    if (clr_i) begin
      min_d = MIN_INIT;
      idx_d = 8'd0;
    end else if (valid_i && (data_i < min_q)) begin
      min_d = data_i;
      idx_d = idx_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= MIN_INIT;
      idx_q <= 8'd0;
    end else begin
      min_q <= min_d;
      idx_q <= idx_d;
    end
  end

  assign min_o     = min_q;
  assign idx_o     = idx_q;
  assign min_nxt_o = min_d;

endmodule

// File: rtl/nonce_min_scan.sv
// Scans NUM_NONCES H0 words, writes {min, index[, found]} record.
// NONCE_MIN_SCAN_TARGET_EN enables the target compare and found word.
module nonce_min_scan
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] input_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  min_nonce,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] res_q;
  logic        done_q;
  logic        found_q;
  logic [7:0]  min_nonce_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;

`ifdef NONCE_MIN_SCAN_TARGET_EN
  logic [31:0] tgt_q;
`else
  logic unused_tgt;
  assign unused_tgt = ^target;
`endif

  logic        trk_clr;
  logic        trk_vld;
  logic [7:0]  trk_idx;
  logic [31:0] trk_min;
  logic [7:0]  trk_win;
  logic [31:0] trk_min_nxt;

  // Read data lags its address by one cycle, so beat k lands
  // while counter k+1 (or DRAIN) is on the bus.
  assign trk_clr = (state_q == S_IDLE) && start;
  assign trk_vld = ((state_q == S_READ) && (cnt_q != 8'd0)) ||
                   (state_q == S_DRAIN);
  assign trk_idx = (state_q == S_DRAIN) ? LAST_IDX : cnt_q - 8'd1;

  min_tracker u_trk (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clr_i     (trk_clr),
    .valid_i   (trk_vld),
    .data_i    (mem_read_data),
    .idx_i     (trk_idx),
    .min_o     (trk_min),
    .idx_o     (trk_win),
    .min_nxt_o (trk_min_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      res_q       <= 16'd0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      min_nonce_q <= 8'd0;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 32'd0;
`ifdef NONCE_MIN_SCAN_TARGET_EN
      tgt_q       <= 32'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            cnt_q   <= 8'd0;
            addr_q  <= input_addr;
            res_q   <= result_addr;
`ifdef NONCE_MIN_SCAN_TARGET_EN
            tgt_q   <= target;
`endif
          end
        end
        S_READ: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= S_DRAIN;
          end else begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_q + 16'd1;
          end
        end
        S_DRAIN: begin
          state_q <= S_WR_HASH;
          we_q    <= 1'b1;
          addr_q  <= res_q + RES_HASH_OFS;
          wdata_q <= trk_min_nxt;
`ifdef NONCE_MIN_SCAN_TARGET_EN
          found_q <= trk_min_nxt < tgt_q;
`else
          found_q <= 1'b0;
`endif
        end
        S_WR_HASH: begin
          state_q     <= S_WR_NONCE;
          addr_q      <= res_q + RES_NONCE_OFS;
          wdata_q     <= {24'd0, trk_win};
          min_nonce_q <= trk_win;
        end
        S_WR_NONCE: begin
`ifdef NONCE_MIN_SCAN_TARGET_EN
          state_q <= S_WR_FOUND;
          addr_q  <= res_q + RES_FOUND_OFS;
          wdata_q <= {31'd0, found_q};
`else
          state_q <= S_FIN;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
`endif
        end
        S_WR_FOUND: begin
          state_q <= S_FIN;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  logic unused_min;
  assign unused_min = ^trk_min;

  assign done           = done_q;
  assign found          = found_q;
  assign min_nonce      = min_nonce_q;
  assign mem_clk        = clk;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_nonce_min_scan.sv
// Bench for nonce_min_scan: memory model, queued reference results,
// and a done-triggered monitor comparing the captured write record.
module tb_nonce_min_scan;

  localparam int N = 16;
`ifdef NONCE_MIN_SCAN_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif
  localparam int NWR = TGT_EN ? 3 : 2;
  localparam int LAT = TGT_EN ? N + 5 : N + 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] input_addr = 16'd0;
  logic [15:0] result_addr = 16'd0;
  logic [31:0] target = 32'd0;
  logic        done;
  logic        found;
  logic [7:0]  min_nonce;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  nonce_min_scan #(.NUM_NONCES(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .input_addr     (input_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .min_nonce      (min_nonce),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'd0;
  logic [31:0] ld_data = 32'd0;

  always @(posedge mem_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hash;
    logic [7:0]  nonce;
    logic        fnd;
    logic [15:0] res;
    int          t0;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] wr_q[$];
  logic [31:0] h [N];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Minimum value first, then the lowest slot holding that value.
  function automatic exp_t model(logic [15:0] res, logic [31:0] tgt, int t0);
    exp_t e;
    logic [31:0] m;
    m = h[0];
    foreach (h[k]) if (h[k] < m) m = h[k];
    e.nonce = 8'd0;
    for (int k = N - 1; k >= 0; k--) if (h[k] == m) e.nonce = 8'(k);
    e.hash = m;
    e.fnd  = TGT_EN && (m < tgt);
    e.res  = res;
    e.t0   = t0;
    return e;
  endfunction

  exp_t        mon_e;
  logic [47:0] ew [3];

  always @(negedge clk) begin
    if (!reset_n) begin
      wr_q.delete();
    end else begin
      if (mem_we) wr_q.push_back({mem_addr, mem_write_data});
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no scan");
        end else begin
          mon_e = exp_q.pop_front();
          ew[0] = {16'(mon_e.res + 16'd0), mon_e.hash};
          ew[1] = {16'(mon_e.res + 16'd1), 24'd0, mon_e.nonce};
          ew[2] = {16'(mon_e.res + 16'd2), 31'd0, mon_e.fnd};
          chk("done_cycle", 32'(cyc - mon_e.t0 + 1), 32'(LAT));
          chk("found", 32'(found), 32'(mon_e.fnd));
          chk("min_nonce", 32'(min_nonce), 32'(mon_e.nonce));
          chk("we_at_done", 32'(mem_we), 32'd0);
          chk("n_writes", 32'(wr_q.size()), 32'(NWR));
          for (int i = 0; i < NWR && i < wr_q.size(); i++) begin
            chk("wr_addr", 32'(wr_q[i][47:32]), 32'(ew[i][47:32]));
            chk("wr_data", wr_q[i][31:0], ew[i][31:0]);
          end
        end
        wr_q.delete();
      end
    end
  end

  task automatic load(logic [15:0] base);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 16'(base + 16'(k));
      ld_data = h[k];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue_start(logic [15:0] ia, logic [15:0] ra,
                             logic [31:0] tg);
    @(negedge clk);
    input_addr  = ia;
    result_addr = ra;
    target      = tg;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    input_addr  = 16'($urandom);
    result_addr = 16'($urandom);
    target      = $urandom;
  endtask

  task automatic run_scan(logic [15:0] ia, logic [15:0] ra,
                          logic [31:0] tg);
    load(ia);
    issue_start(ia, ra, tg);
    exp_q.push_back(model(ra, tg, cyc));
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("rd_addr", 32'(mem_addr), 32'(16'(ia + 16'(k))));
      chk("rd_we", 32'(mem_we), 32'd0);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d", LAT);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_nonce", 32'(min_nonce), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (h[k]) h[k] = 32'h1000_0000 + 32'(k);
    h[9] = 32'h0000_00FF;
    run_scan(16'h0100, 16'h0800, 32'h0001_0000);

    foreach (h[k]) h[k] = 32'h0000_0005;
    run_scan(16'h0200, 16'h0810, 32'h0000_0005);

    foreach (h[k]) h[k] = 32'hFFFF_FFFF;
    h[15] = 32'd0;
    run_scan(16'h0300, 16'h0820, 32'h0000_0010);

    foreach (h[k]) h[k] = $urandom;
    run_scan(16'hFFF8, 16'hFFFE, $urandom);

    // Extra start during READ, then reset mid-scan.
    foreach (h[k]) h[k] = $urandom;
    load(16'h0400);
    issue_start(16'h0400, 16'h0830, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_no_wr", 32'(wr_q.size()), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", mem_write_data, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_nonce", 32'(min_nonce), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_wr", 32'(wr_q.size()), 32'd0);
    run_scan(16'h0400, 16'h0830, 32'h8000_0000);

    for (int r = 0; r < 6; r++) begin
      foreach (h[k]) h[k] = (r % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_scan(16'($urandom), 16'($urandom), (r % 2 == 0) ? 32'($urandom_range(0, 4)) : $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonce_min_scan.md
# nonce_min_scan

Post-processing stage downstream of the 16-nonce Bitcoin hasher. After the hasher has written its per-nonce H0 words to memory, this block reads them back and selects the smallest H0, lowest nonce index on ties. It compares that minimum against a difficulty target and writes a small result record (minimum hash, winning nonce, found flag) to memory. It uses the same single-port testbench memory interface as the hasher and runs after it, not concurrently.

## Interface
- `NUM_NONCES`, default 16: number of consecutive H0 words to scan; legal values 2..256.
- `clk` input, 1 bit: system clock; also drives `mem_clk`.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a scan; sampled only in IDLE.
- `input_addr` input, 16 bits: word address of H0 for nonce 0 (the hasher's output_addr).
- `result_addr` input, 16 bits: word address of the result record.
- `target` input, 32 bits: difficulty threshold for the found flag.
- `done` output, 1 bit: one-cycle completion pulse.
- `found` output, 1 bit: registered result flag, valid from `done` until the next accepted `start`.
- `min_nonce` output, 8 bits: registered winning nonce index, with the same validity as `found`.
- `mem_clk` output, 1 bit: equal to `clk`.
- `mem_we` output, 1 bit: memory write enable.
- `mem_addr` output, 16 bits: memory word address.
- `mem_write_data` output, 32 bits: memory write data.
- `mem_read_data` input, 32 bits: memory read data; valid the cycle after the address is presented.

## Operation
- States:
  - IDLE: the only state that samples `start`.
  - READ: presents the read addresses; the next read datum is compared in the following cycle.
  - DRAIN: compares the last datum.
  - WR_HASH, WR_NONCE, WR_FOUND: one memory write each.
  - FIN: asserts `done`.
- Transitions:
  - IDLE→READ on `start`.
  - READ→DRAIN after `NUM_NONCES` read addresses have been issued.
  - DRAIN→WR_HASH→WR_NONCE→WR_FOUND→FIN→IDLE.
- On accepting `start`:
  - latch `input_addr`, `result_addr` and `target`;
  - clear the read counter;
  - set the running minimum to 32'hFFFFFFFF and the running index to 0.
  - Later changes to these inputs during the scan have no effect.
- Update rule: an incoming word replaces the running minimum only when it is strictly less than it (unsigned 32-bit). On ties the lower index is kept.
- Data beat k (k = 0..NUM_NONCES-1) is the datum for address `input_addr+k` and carries index k.
- `found` = (minimum < target), an unsigned strict compare computed in DRAIN.
- Result record:
  - `result_addr+0` = minimum H0;
  - `result_addr+1` = winning index, zero-extended to 32 bits;
  - `result_addr+2` = {31'b0, found}.
- Address arithmetic is 16-bit and wraps modulo 2^16 (input_addr=16'hFFFF reads 16'hFFFF, 16'h0000, ...).
- `start` in any non-IDLE state is ignored.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_write_data`=0, `done`=0, `found`=0, `min_nonce`=0, state=IDLE.
- Reset asserted mid-scan: abort immediately; `mem_we` drops asynchronously. No partial record is completed.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..N (N = `NUM_NONCES`): `mem_addr` = `input_addr`+0..N-1, with `mem_we`=0.
- Cycles 2..N+1: compare beats 0..N-1.
- Cycles N+2, N+3, N+4: writes with `mem_we`=1, in the order hash, nonce, found.
- Cycle N+5: `done`=1 for exactly one cycle; `mem_we`=0.
- Cycle N+6: back in IDLE; a new `start` is accepted here at the earliest.
- Total latency from `start` to `done`: N+5 cycles (21 for N=16).
- All outputs are registered except `mem_clk`.

## Configuration
- `NONCE_MIN_SCAN_TARGET_EN` defined:
  - `target` compare is active;
  - the record is three words;
  - latency is N+5.
- Not defined:
  - `target` is ignored and `found` is tied to 0;
  - WR_FOUND is skipped, so the record is two words (hash, nonce);
  - `done` arrives at cycle N+4.

## Structure
- Shared package `bitcoin_pkg`:
  - state enum type;
  - result offset constants `RES_HASH_OFS`=0, `RES_NONCE_OFS`=1, `RES_FOUND_OFS`=2;
  - `MIN_INIT`=32'hFFFFFFFF.
- One sub-module, `min_tracker`: it holds the running minimum and index, and has clear, valid, data and index inputs. The top level holds the FSM, the address counter and the write mux.

## Test plan
- Distinct minimum: H0 = 32'h1000_0000+k for k≠9, H0[9] = 32'h0000_00FF; target = 32'h0001_0000 → record {0x000000FF, 9, 1}; `done` at cycle 21; `min_nonce`=9.
- All words equal 32'h0000_0005, target = 5 → record {5, 0, 0} (lowest-index tie-break; strict compare gives found=0).
- Minimum in the last slot: H0[15] = 0, all others 32'hFFFF_FFFF → record {0, 15, 1}. This checks the DRAIN-cycle compare.
- Address wrap: `input_addr`=16'hFFF8 and `result_addr`=16'hFFFE → reads issued at 0xFFF8..0x0007; writes land at 0xFFFE, 0xFFFF, 0x0000.
- `start` pulsed during READ, then `reset_n` pulsed low at cycle 10 → no extra scan; `mem_we` stays 0; outputs return to reset values. A fresh `start` afterwards completes normally.
- Macro off: the same stimulus as the first scenario → only two writes, {0xFF, 9}; `found`=0; `done` at cycle 20.
